instr_boot_loader: RTL and testbench
====================================

// Module: instr_boot_loader
// PURPOSE
//  Upstream boot stage for the single-cycle MIPS core. Receives a byte stream over a valid/ready
//  handshake, packs the bytes into 32-bit big-endian words and writes them into instruction memory
//  from word address 0 upward. Holds the core in reset until the image is complete.
//  Then releases CpuReset so that PCUnit starts fetching at address 0.
// PARAMETERS
//  ADDR_W     10    IM word-address width; matches the InstrAddr[9:0] port of InstrMem
//  MAX_WORDS  1024  largest accepted image, in words; must be <= 2**ADDR_W
// PORTS
//  Clock        in   1       system clock; all state changes on the rising edge
//  Reset        in   1       asynchronous, active-high; clears all state
//  InData       in   8       stream byte
//  InValid      in   1       InData is valid this cycle
//  InReady      out  1       loader accepts a byte; transfer when InValid & InReady at posedge
//  IMWriteEn    out  1       one-cycle instruction-memory write strobe
//  IMWriteAddr  out  ADDR_W  word address for IMWriteEn
//  IMWriteData  out  32      word for IMWriteEn
//  CpuReset     out  1       drives the core's Reset; high until the load completes
//  Done         out  1       image loaded; core running
//  Error        out  1       load aborted; core held in reset
// BEHAVIOUR
//  Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes.
//   Each data word is sent MSB first.
//  FSM states: LEN_HI -> LEN_LO -> DATA -> [CKSUM] -> DONE. ERR is terminal.
//   Only Reset leaves DONE or ERR.
//  LEN_LO accept: N==0 -> DONE (or CKSUM). N>MAX_WORDS -> ERR. Otherwise -> DATA.
//  DATA:
//   - A byte counter (2 bits) shifts bytes into a 32-bit register.
//   - On the accept of the 4th byte, the cycle after has IMWriteEn=1, IMWriteData=the packed word,
//     and IMWriteAddr=the word index (0,1,2,...).
//   - InReady=0 during that write cycle; single buffering, so max throughput is 4 bytes per 5 cycles.
//   - After writing word N-1, the next cycle enters DONE (or CKSUM).
//  InReady=1 in LEN_HI, LEN_LO, DATA (except the write cycle) and CKSUM; InReady=0 in DONE and ERR.
//  Bytes offered while InReady=0 are not consumed. The source must hold them.
//  InValid low mid-word: the partial word is retained indefinitely. There is no timeout.
//  Outputs:
//   - CpuReset=1 in every state except DONE; it goes low on the clock edge that enters DONE.
//   - Done=1 only in DONE. Error=1 only in ERR.
//  IMWriteAddr is held at the last written address between strobes. IMWriteData holds its last value.
//  Reset values: state=LEN_HI, InReady=1, IMWriteEn=0, IMWriteAddr=0, IMWriteData=0, CpuReset=1,
//   Done=0, Error=0. All counters and the shift register are 0.
//  Reset mid-load: the load is abandoned immediately. Already-written IM words are not erased.
//   The next stream restarts at LEN_HI and word 0.
//  Word counter is ADDR_W+1 bits wide, so N==2**ADDR_W completes without wrap.
// CONFIGURATION
//  INSTR_BOOT_CKSUM_EN defined: after the last data byte (or after LEN_LO if N==0) one extra byte
//   is accepted in state CKSUM. It must equal the XOR of every preceding stream byte, including
//   LEN_HI and LEN_LO. Match -> DONE. Mismatch -> ERR.
//  INSTR_BOOT_CKSUM_EN undefined: the CKSUM state and the XOR accumulator are absent.
//   Completion goes directly to DONE.
// TESTING
//  1 Reset, then send 00 01 24 08 00 05 -> one IMWriteEn with addr 0, data 32'h24080005.
//    Then Done=1, CpuReset=0, InReady=0.
//  2 N=3, bytes sent back-to-back with InValid held high -> writes at addr 0,1,2.
//    InReady drops exactly one cycle after each 4th byte. Done is asserted 1 cycle after the 3rd write.
//  3 Send 00 00 -> no IMWriteEn; Done=1 (checksum off).
//    With INSTR_BOOT_CKSUM_EN: 00 00 00 -> Done=1. 00 00 5A -> Error=1, CpuReset=1.
//  4 Send 04 01 (N=1025 > MAX_WORDS) -> Error=1, InReady=0, no IMWriteEn, CpuReset stays 1.
//  5 InValid deasserted for 10 cycles after byte 2 of a word -> no write during the gap.
//    The word completes correctly after the remaining bytes arrive.
//  6 Reset pulse after 2 of 4 words -> all outputs return to reset values.
//    A fresh 00 01 stream then writes addr 0.

Source files
------------

// File: rtl/instr_boot_loader.sv
// Boot-stage byte-stream loader: packs big-endian words into instruction memory and holds the core in reset until the image is in.
// Optional trailing XOR checksum byte is enabled by defining INSTR_BOOT_CKSUM_EN.
module instr_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        InData,
  input  logic              InValid,
  output logic              InReady,
  output logic              IMWriteEn,
  output logic [ADDR_W-1:0] IMWriteAddr,
  output logic [31:0]       IMWriteData,
  output logic              CpuReset,
  output logic              Done,
  output logic              Error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef INSTR_BOOT_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef INSTR_BOOT_CKSUM_EN
  localparam state_t S_FINISH = S_CKSUM;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef INSTR_BOOT_CKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic        accept;
  logic [16:0] len_lo_n;
  logic [16:0] wcnt_next;

  // The write cycle blocks intake so the single pack register cannot be overrun.
  always_comb begin
    InReady = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO: InReady = 1'b1;
      S_DATA:             InReady = !wen_q;
`ifdef INSTR_BOOT_CKSUM_EN
      S_CKSUM:            InReady = 1'b1;
`endif
      default:            InReady = 1'b0;
    endcase
  end

  assign accept    = InValid & InReady;
  assign len_lo_n  = {1'b0, len_q[15:8], InData};
  assign wcnt_next = 17'(wcnt_q) + 17'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    wcnt_d  = wcnt_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef INSTR_BOOT_CKSUM_EN
    xor_d   = xor_q;
    if (accept && state_q != S_CKSUM) begin
      xor_d = xor_q ^ InData;
    end
`endif
    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = InData;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = InData;
          if (len_lo_n == 17'd0) begin
            state_d = S_FINISH;
          end else if (len_lo_n > MAX_N) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (wen_q) begin
          wcnt_d = wcnt_q + (ADDR_W+1)'(1);
          if (wcnt_next == {1'b0, len_q}) begin
            state_d = S_FINISH;
          end
        end else if (accept) begin
          shift_d = {shift_q[15:0], InData};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wen_d   = 1'b1;
            wdata_d = {shift_q, InData};
            addr_d  = wcnt_q[ADDR_W-1:0];
          end
        end
      end
`ifdef INSTR_BOOT_CKSUM_EN
      S_CKSUM: begin
        if (accept) begin
          state_d = (InData == xor_q) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_LEN_HI;
      len_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      wcnt_q  <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef INSTR_BOOT_CKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      wcnt_q  <= wcnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef INSTR_BOOT_CKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign IMWriteEn   = wen_q;
  assign IMWriteAddr = addr_q;
  assign IMWriteData = wdata_q;
  assign CpuReset    = (state_q != S_DONE);
  assign Done        = (state_q == S_DONE);
  assign Error       = (state_q == S_ERR);

endmodule

// File: tb/tb_instr_boot_loader.sv
// Bench for instr_boot_loader: table of whole streams plus hand-written gap / reset sequences.
// Expected IM writes go through a scoreboard queue checked by a negedge monitor.
module tb_instr_boot_loader;
  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic [7:0]        InData = 8'h00;
  logic              InValid = 1'b0;
  logic              InReady;
  logic              IMWriteEn;
  logic [ADDR_W-1:0] IMWriteAddr;
  logic [31:0]       IMWriteData;
  logic              CpuReset;
  logic              Done;
  logic              Error;

  instr_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .Clock(Clock), .Reset(Reset), .InData(InData), .InValid(InValid), .InReady(InReady),
    .IMWriteEn(IMWriteEn), .IMWriteAddr(IMWriteAddr), .IMWriteData(IMWriteData),
    .CpuReset(CpuReset), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0]  len_hi;
    logic [7:0]  len_lo;
    logic [31:0] base;
    logic        exp_done;
    logic        exp_err;
    int          exp_writes;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int   errors = 0;
  int   checks = 0;
  int   writes_seen = 0;
  wr_t  sb[$];
  wr_t  mon_e;
  logic [7:0] xor_acc = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] base, input int i);
    return base ^ (32'(i) * 32'h9E3779B1);
  endfunction

  always @(negedge Clock) begin
    if (!Reset && IMWriteEn === 1'b1) begin
      writes_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", IMWriteAddr, IMWriteData);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(IMWriteAddr), 32'(mon_e.addr));
        check("wr_data", IMWriteData, mon_e.data);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_inready"},  32'(InReady),     32'd1);
    check({tag, "_wen"},      32'(IMWriteEn),   32'd0);
    check({tag, "_waddr"},    32'(IMWriteAddr), 32'd0);
    check({tag, "_wdata"},    IMWriteData,      32'd0);
    check({tag, "_cpureset"}, 32'(CpuReset),    32'd1);
    check({tag, "_done"},     32'(Done),        32'd0);
    check({tag, "_error"},    32'(Error),       32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset   = 1'b1;
    InValid = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    sb.delete();
    writes_seen = 0;
    xor_acc = 8'h00;
    check_reset_vals("rst");
  endtask

  // Offer a byte from a negedge, wait for InReady (bounded), transfer on the next posedge.
  task automatic send_byte(input logic [7:0] b, output int stalls);
    int n;
    n = 0;
    @(negedge Clock);
    InData  = b;
    InValid = 1'b1;
    while (InReady !== 1'b1 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got InReady %b expected 1 within 200 cycles", InReady);
    end
    xor_acc = xor_acc ^ b;
    @(posedge Clock);
    #1 InValid = 1'b0;
    stalls = n;
  endtask

  task automatic send_word(input logic [31:0] w, output int first_stalls);
    int s;
    send_byte(w[31:24], first_stalls);
    send_byte(w[23:16], s);
    send_byte(w[15:8],  s);
    send_byte(w[7:0],   s);
  endtask

  task automatic send_cksum();
`ifdef INSTR_BOOT_CKSUM_EN
    int s;
    logic [7:0] ck;
    ck = xor_acc;
    send_byte(ck, s);
`endif
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int s;
    int n;
    wr_t e;
    logic [31:0] w;
    do_reset();
    n = int'({v.len_hi, v.len_lo});
    send_byte(v.len_hi, s);
    send_byte(v.len_lo, s);
    if (!v.exp_err) begin
      for (int i = 0; i < n; i++) begin
        w = word_of(v.base, i);
        e.addr = ADDR_W'(i);
        e.data = w;
        sb.push_back(e);
        send_word(w, s);
        check($sformatf("v%0d_stall_w%0d", idx, i), 32'(s), (i == 0) ? 32'd0 : 32'd1);
      end
      if (n > 0) begin
        @(negedge Clock);
        check($sformatf("v%0d_last_wen", idx), 32'(IMWriteEn), 32'd1);
        check($sformatf("v%0d_done_early", idx), 32'(Done), 32'd0);
      end
      send_cksum();
    end
    @(negedge Clock);
    check($sformatf("v%0d_done", idx),     32'(Done),     32'(v.exp_done));
    check($sformatf("v%0d_error", idx),    32'(Error),    32'(v.exp_err));
    check($sformatf("v%0d_cpureset", idx), 32'(CpuReset), 32'(!v.exp_done));
    check($sformatf("v%0d_inready", idx),  32'(InReady),  32'd0);
    repeat (3) @(negedge Clock);
    check($sformatf("v%0d_writes", idx),   32'(writes_seen), 32'(v.exp_writes));
    check($sformatf("v%0d_sb_empty", idx), 32'(sb.size()),   32'd0);
    $display("vec %0d: N=%0d done=%b error=%b writes=%0d", idx, n, Done, Error, writes_seen);
  endtask

  vec_t vecs[8];

  initial begin
    int s;
    wr_t e;

    vecs[0] = '{8'h00, 8'h01, 32'h24080005, 1'b1, 1'b0, 1};
    vecs[1] = '{8'h00, 8'h03, 32'hA1B2C3D4, 1'b1, 1'b0, 3};
    vecs[2] = '{8'h00, 8'h00, 32'h00000000, 1'b1, 1'b0, 0};
    vecs[3] = '{8'h04, 8'h01, 32'h00000000, 1'b0, 1'b1, 0};
    vecs[4] = '{8'h00, 8'h02, 32'hDEADBEEF, 1'b1, 1'b0, 2};
    vecs[5] = '{8'h04, 8'h00, 32'h13579BDF, 1'b1, 1'b0, 1024};
    vecs[6] = '{8'hFF, 8'hFF, 32'h00000000, 1'b0, 1'b1, 0};
    vecs[7] = '{8'h00, 8'h07, 32'h0F1E2D3C, 1'b1, 1'b0, 7};

    repeat (2) @(negedge Clock);
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

`ifdef INSTR_BOOT_CKSUM_EN
    // Bad checksum byte after an empty image
    do_reset();
    send_byte(8'h00, s);
    send_byte(8'h00, s);
    send_byte(8'h5A, s);
    @(negedge Clock);
    check("ck_bad_error",    32'(Error),    32'd1);
    check("ck_bad_cpureset", 32'(CpuReset), 32'd1);
    check("ck_bad_done",     32'(Done),     32'd0);
    $display("cksum mismatch: error=%b cpureset=%b", Error, CpuReset);
`endif

    // Source stalls for 10 cycles in the middle of a word
    do_reset();
    send_byte(8'h00, s);
    send_byte(8'h01, s);
    e.addr = '0;
    e.data = 32'h11223344;
    sb.push_back(e);
    send_byte(8'h11, s);
    send_byte(8'h22, s);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check("gap_no_wen", 32'(IMWriteEn), 32'd0);
    end
    send_byte(8'h33, s);
    send_byte(8'h44, s);
    send_cksum();
    repeat (2) @(negedge Clock);
    check("gap_done",   32'(Done),        32'd1);
    check("gap_writes", 32'(writes_seen), 32'd1);
    $display("gap: done=%b writes=%0d", Done, writes_seen);

    // Asynchronous reset after 2 of 4 words, then a fresh one-word image
    do_reset();
    send_byte(8'h00, s);
    send_byte(8'h04, s);
    for (int i = 0; i < 2; i++) begin
      e.addr = ADDR_W'(i);
      e.data = word_of(32'hCAFEF00D, i);
      sb.push_back(e);
      send_word(e.data, s);
    end
    repeat (2) @(negedge Clock);
    check("mid_writes", 32'(writes_seen), 32'd2);
    #2 Reset = 1'b1;
    #1 check_reset_vals("async");
    @(negedge Clock);
    Reset = 1'b0;
    writes_seen = 0;
    xor_acc = 8'h00;
    sb.delete();
    send_byte(8'h00, s);
    send_byte(8'h01, s);
    e.addr = '0;
    e.data = 32'h8C220004;
    sb.push_back(e);
    send_word(e.data, s);
    send_cksum();
    repeat (2) @(negedge Clock);
    check("restart_done",   32'(Done),        32'd1);
    check("restart_writes", 32'(writes_seen), 32'd1);
    check("restart_sb",     32'(sb.size()),   32'd0);
    $display("restart: done=%b writes=%0d", Done, writes_seen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
